wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the register-file write port.
REQ-002 Parameter NREQ, default 2, number of write-back requesters; legal range 2..4.
REQ-003 clk_i  input  1  sole clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  NREQ  per-requester write request valid.
REQ-006 req_rd_i  input  NREQ*5  per-requester destination register index.
REQ-007 req_data_i  input  NREQ*XLEN  per-requester write data.
REQ-008 req_ready_o  output  NREQ  per-requester accept; transfer when valid and ready both high.
REQ-009 flush_i  input  1  kill the write registered in the current cycle.
REQ-010 rf_wen_o  output  1  register-file write enable, registered.
REQ-011 rf_waddr_o  output  5  register-file write address, registered.
REQ-012 rf_wdata_o  output  XLEN  register-file write data, registered.
REQ-013 byp_rs1_i, byp_rs2_i  input  5 each  read indices for bypass compare (only with WB_ARB_BYPASS_EN).
REQ-014 byp_hit1_o, byp_hit2_o  output  1 each  bypass hit flags (only with WB_ARB_BYPASS_EN).

Function
REQ-015 The block SHALL grant at most one requester per cycle; req_ready_o SHALL be one-hot or zero.
REQ-016 req_ready_o SHALL be combinational from req_valid_i and the priority pointer; no requester SHALL see ready while its valid is low.
REQ-017 Arbitration SHALL be round-robin: search starts at index ptr+1 modulo NREQ, lowest index after ptr wins.
REQ-018 The pointer ptr SHALL update to the granted index on every transfer and hold otherwise.
REQ-019 Latency SHALL be exactly one cycle: a transfer in cycle N drives rf_wen_o/rf_waddr_o/rf_wdata_o in cycle N+1.
REQ-020 A transfer with rd = 0 SHALL be accepted (ready high) but SHALL produce rf_wen_o = 0 in N+1.
REQ-021 rf_wen_o SHALL be 0 in any cycle following a cycle without a transfer; rf_waddr_o/rf_wdata_o SHALL hold their last values.
REQ-022 flush_i high in cycle N SHALL force rf_wen_o = 0 in N+1 and SHALL NOT update ptr; req_ready_o SHALL still be issued (flushed request is consumed and dropped).
REQ-023 Two requesters targeting the same rd in consecutive cycles SHALL both be written in grant order; last grant wins in the register file.
REQ-024 The output stage never back-pressures; the block SHALL sustain one transfer per cycle indefinitely.

Reset
REQ-025 While rst_i is low: rf_wen_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, ptr = NREQ-1 (requester 0 wins first), req_ready_o = 0.
REQ-026 Reset assertion mid-transfer SHALL discard the pending write; first grant after release SHALL follow REQ-025 pointer value.

Configuration
REQ-027 Macro WB_ARB_BYPASS_EN defined: byp_hitK_o = rf_wen_o and (rf_waddr_o == byp_rsK_i), combinational.
REQ-028 Macro WB_ARB_BYPASS_EN undefined: bypass ports SHALL be absent; no compare logic SHALL be synthesised.

Structure
REQ-029 Shared package wb_pkg SHALL hold REG_IDX_W = 5, the default XLEN, and a packed struct wb_req_t {rd, data}.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector and ptr, output one-hot grant); output stage stays in wb_arbiter.

Verification
REQ-031 Reset: hold rst_i low 3 cycles with all valids high -> req_ready_o = 0, rf_wen_o = 0, outputs all zero.
REQ-032 Contention: NREQ=2, both valid 4 cycles, rd 5 and 6 -> grants 0,1,0,1; rf_waddr_o 5,6,5,6 one cycle later, rf_wen_o high each cycle.
REQ-033 x0: requester 1 valid alone with rd 0, data 0xDEADBEEF -> ready high, rf_wen_o = 0 next cycle.
REQ-034 Flush: requester 0 rd 7 data 0x12 with flush_i high same cycle -> ready high, rf_wen_o = 0 next cycle, next contention grant still starts at requester 0.
REQ-035 Bypass (macro defined): transfer rd 9, then byp_rs1_i = 9, byp_rs2_i = 10 -> byp_hit1_o = 1, byp_hit2_o = 0 in that output cycle.
REQ-036 Async reset: drop rst_i between clock edges while rf_wen_o = 1 -> rf_wen_o falls immediately, no write on the following edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
package wb_pkg;

    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned XLEN_DEFAULT = 32;

    // One write-back request as seen by the register file.
    typedef struct packed {
        logic [REG_IDX_W-1:0]    rd;
        logic [XLEN_DEFAULT-1:0] data;
    } wb_req_t;

    // Writes to x0 are accepted but never reach the register file.
    function automatic logic is_x0(input logic [REG_IDX_W-1:0] rd);
        return (rd == '0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts just after ptr_i, first valid requester wins.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Rotating priority search, one-hot or zero result.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % int'(NREQ));
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin pick of NREQ requesters into one registered
// register-file write port. Define WB_ARB_BYPASS_EN to add the bypass-hit ports.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREQ = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
`ifdef WB_ARB_BYPASS_EN
    input  logic [REG_IDX_W-1:0]      byp_rs1_i,
    input  logic [REG_IDX_W-1:0]      byp_rs2_i,
    output logic                      byp_hit1_o,
    output logic                      byp_hit2_o,
`endif
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*REG_IDX_W-1:0] req_rd_i,
    input  logic [NREQ*XLEN-1:0]      req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic                      flush_i,
    output logic                      rf_wen_o,
    output logic [REG_IDX_W-1:0]      rf_waddr_o,
    output logic [XLEN-1:0]           rf_wdata_o
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0]     ptr_q;
    logic [NREQ-1:0]      grant;
    logic [PTR_W-1:0]     gnt_idx;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic                 xfer;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Ready is suppressed while reset is held even though the grant is combinational.
    assign req_ready_o = grant & {NREQ{rst_i}};
    assign xfer        = |grant;

    // Select the granted requester's index and payload.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        gnt_idx  = ptr_q;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd_i[i*REG_IDX_W +: REG_IDX_W];
                sel_data = req_data_i[i*XLEN +: XLEN];
                gnt_idx  = PTR_W'(i);
            end
        end
    end

    // Output register and priority pointer; a flushed transfer is consumed but leaves ptr alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rf_wen_o   <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
            ptr_q      <= PTR_W'(NREQ - 1);
        end else begin
            rf_wen_o <= xfer && !flush_i && !is_x0(sel_rd);
            if (xfer) begin
                rf_waddr_o <= sel_rd;
                rf_wdata_o <= sel_data;
                if (!flush_i) begin
                    ptr_q <= gnt_idx;
                end
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    // Combinational forwarding hits against the write currently on the port.
    assign byp_hit1_o = rf_wen_o && (rf_waddr_o == byp_rs1_i);
    assign byp_hit2_o = rf_wen_o && (rf_waddr_o == byp_rs2_i);
`endif

endmodule
